// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction-cache valid-RAM
// invalidate sequencer.
package icache_pkg;

    localparam int DEF_DATA_WIDTH_BITS       = 1;
    localparam int DEF_ADDR_WIDTH            = 6;
    localparam int DEF_INVALIDATE_WIDTH_BITS = 6;
    localparam int DEF_INVALIDATE_ADDR_WIDTH = 1;

    localparam int DW    = 2 ** DEF_DATA_WIDTH_BITS;
    localparam int IW    = 2 ** DEF_INVALIDATE_WIDTH_BITS;
    localparam int LSB_W = DEF_INVALIDATE_WIDTH_BITS - DEF_DATA_WIDTH_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        LREAD  = 3'd2,
        LWRITE = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/icache_invalidate_ctrl.sv
// Drives the invalidate port of the icache valid-bit RAM: full-row sweep for
// fence.i, or read-modify-write of one row to clear selected way bits.
module icache_invalidate_ctrl
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH_BITS       = DEF_DATA_WIDTH_BITS,
    parameter int ADDR_WIDTH            = DEF_ADDR_WIDTH,
    parameter int INVALIDATE_WIDTH_BITS = DEF_INVALIDATE_WIDTH_BITS,
    parameter int INVALIDATE_ADDR_WIDTH = DEF_INVALIDATE_ADDR_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_flush,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    input  logic [2**DATA_WIDTH_BITS-1:0]         req_mask,
    output logic                                  done,
    output logic                                  busy,
    output logic                                  ien,
    output logic                                  invalidate,
    output logic [INVALIDATE_ADDR_WIDTH-1:0]      iaddr,
    output logic [2**INVALIDATE_WIDTH_BITS-1:0]   idata,
    input  logic [2**INVALIDATE_WIDTH_BITS-1:0]   dummy_data
);

    localparam int M_DW  = 2 ** DATA_WIDTH_BITS;
    localparam int M_IW  = 2 ** INVALIDATE_WIDTH_BITS;
    localparam int IAW   = INVALIDATE_ADDR_WIDTH;
    localparam int M_LSB = ADDR_WIDTH - INVALIDATE_ADDR_WIDTH;

    state_e                       state_r;
    state_e                       state_nxt_s;
    logic [IAW-1:0]               count_r;
    logic [ADDR_WIDTH-1:0]        cmd_addr_r;
    logic [M_DW-1:0]              cmd_mask_r;
    logic                         accept_s;
    logic [IAW-1:0]               row_s;
    logic [M_LSB-1:0]             lsb_s;
    logic [INVALIDATE_WIDTH_BITS-1:0] shamt_s;
    logic [M_IW-1:0]              clear_s;

    assign req_ready = (state_r == IDLE) && !reset;
    assign busy      = (state_r != IDLE);
    assign accept_s  = req_valid && req_ready;

    // Row/bit position of the latched line; a line's DW way bits sit at lsb*DW.
    assign row_s   = cmd_addr_r[ADDR_WIDTH-1 -: IAW];
    assign lsb_s   = cmd_addr_r[M_LSB-1:0];
    assign shamt_s = {lsb_s, {DATA_WIDTH_BITS{1'b0}}};
    assign clear_s = {{(M_IW-M_DW){1'b0}}, cmd_mask_r} << shamt_s;

    // State, flush row counter and latched command.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= {IAW{1'b0}};
            cmd_addr_r <= {ADDR_WIDTH{1'b0}};
            cmd_mask_r <= {M_DW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cmd_addr_r <= req_addr;
                cmd_mask_r <= req_mask;
            end
            if (accept_s && req_flush) begin
                count_r <= {IAW{1'b0}};
            end else if (state_r == FLUSH) begin
                count_r <= count_r + IAW'(1);
            end
        end
    end

    // Next state and invalidate-port decode from registered state.
    always_comb begin
        state_nxt_s = state_r;
        done        = 1'b0;
        ien         = 1'b0;
        invalidate  = 1'b0;
        iaddr       = {IAW{1'b0}};
        idata       = {M_IW{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_flush) begin
                        state_nxt_s = FLUSH;
                    end else begin
                        state_nxt_s = LREAD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FLUSH: begin
                ien        = 1'b1;
                invalidate = 1'b1;
                iaddr      = count_r;
                if (count_r == {IAW{1'b1}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            LREAD: begin
                ien         = 1'b1;
                iaddr       = row_s;
                state_nxt_s = LWRITE;
            end
            LWRITE: begin
                ien         = 1'b1;
                invalidate  = 1'b1;
                iaddr       = row_s;
                idata       = dummy_data & ~clear_s;
                state_nxt_s = DONE;
            end
            DONE: begin
                done        = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_invalidate_ctrl.sv
// Directed bench for icache_invalidate_ctrl with a queue-based scoreboard.
module tb_icache_invalidate_ctrl;
    import icache_pkg::*;

    localparam int IAW = DEF_INVALIDATE_ADDR_WIDTH;
    localparam int AW  = DEF_ADDR_WIDTH;
    localparam int R   = 2 ** IAW;

    typedef struct packed {
        logic           ready;
        logic           busy;
        logic           done;
        logic           ien;
        logic           inv;
        logic [IAW-1:0] iaddr;
        logic [IW-1:0]  idata;
    } out_t;

    typedef struct {
        string tag;
        out_t  o;
    } sb_t;

    logic           clock;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           req_flush;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_mask;
    logic           done;
    logic           busy;
    logic           ien;
    logic           invalidate;
    logic [IAW-1:0] iaddr;
    logic [IW-1:0]  idata;
    logic [IW-1:0]  dummy_data;

    sb_t sb_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    icache_invalidate_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_flush  (req_flush),
        .req_addr   (req_addr),
        .req_mask   (req_mask),
        .done       (done),
        .busy       (busy),
        .ien        (ien),
        .invalidate (invalidate),
        .iaddr      (iaddr),
        .idata      (idata),
        .dummy_data (dummy_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic out_t mk(logic rdy, logic bsy, logic dn, logic en, logic inv,
                                logic [IAW-1:0] ia, logic [IW-1:0] id);
        out_t o;
        o.ready = rdy; o.busy = bsy; o.done = dn; o.ien = en; o.inv = inv;
        o.iaddr = ia;  o.idata = id;
        return o;
    endfunction

    // Expected write-back: bit i belongs to line i/DW, way i%DW.
    function automatic logic [IW-1:0] rmw(logic [AW-1:0] a, logic [DW-1:0] m, logic [IW-1:0] dd);
        logic [IW-1:0] r;
        int lsb;
        lsb = int'(a) % (IW / DW);
        for (int i = 0; i < IW; i++) begin
            r[i] = dd[i] & ~((i / DW) == lsb && m[i % DW]);
        end
        return r;
    endfunction

    function automatic logic [IAW-1:0] row_of(logic [AW-1:0] a);
        return IAW'(int'(a) / (IW / DW));
    endfunction

    // One cycle: queue the expectation, drive inputs after negedge, then compare.
    task automatic step(string tag, logic v, logic fl, logic [AW-1:0] a, logic [DW-1:0] m,
                        logic rst, logic [IW-1:0] dd, out_t e);
        sb_t  s;
        out_t obs;
        sb_q.push_back('{tag, e});
        @(negedge clock);
        req_valid = v; req_flush = fl; req_addr = a; req_mask = m;
        reset = rst; dummy_data = dd;
        #1;
        s   = sb_q.pop_front();
        obs = {req_ready, busy, done, ien, invalidate, iaddr, idata};
        n_vec++;
        assert (obs === s.o) else begin
            n_miss++;
            $error("FAIL %s: observed rdy=%b busy=%b done=%b ien=%b inv=%b iaddr=%h idata=%h expected rdy=%b busy=%b done=%b ien=%b inv=%b iaddr=%h idata=%h",
                   s.tag, obs.ready, obs.busy, obs.done, obs.ien, obs.inv, obs.iaddr, obs.idata,
                   s.o.ready, s.o.busy, s.o.done, s.o.ien, s.o.inv, s.o.iaddr, s.o.idata);
        end
    endtask

    // Flush from acceptance through the done pulse.
    task automatic run_flush(string tag, logic hold_valid);
        step({tag, "_acc"}, 1'b1, 1'b1, '0, '0, 1'b0, '0, mk(1, 0, 0, 0, 0, '0, '0));
        for (int r = 0; r < R; r++) begin
            step({tag, "_wr"}, hold_valid, 1'b1, '0, '0, 1'b0, '1, mk(0, 1, 0, 1, 1, IAW'(r), '0));
        end
        step({tag, "_done"}, hold_valid, 1'b1, '0, '0, 1'b0, '0, mk(0, 1, 1, 0, 0, '0, '0));
    endtask

    // Line invalidate from acceptance through the done pulse.
    task automatic run_line(string tag, logic [AW-1:0] a, logic [DW-1:0] m, logic [IW-1:0] dd);
        step({tag, "_acc"}, 1'b1, 1'b0, a, m, 1'b0, dd, mk(1, 0, 0, 0, 0, '0, '0));
        step({tag, "_rd"}, 1'b0, 1'b0, '0, '0, 1'b0, dd, mk(0, 1, 0, 1, 0, row_of(a), '0));
        step({tag, "_wr"}, 1'b0, 1'b0, '0, '0, 1'b0, dd, mk(0, 1, 0, 1, 1, row_of(a), rmw(a, m, dd)));
        step({tag, "_done"}, 1'b0, 1'b0, '0, '0, 1'b0, dd, mk(0, 1, 1, 0, 0, '0, '0));
    endtask

    initial begin
        logic [IW-1:0] dd;
        logic [IW-1:0] fixed_exp;
        out_t zero_o;
        out_t idle_o;
        zero_o    = mk(0, 0, 0, 0, 0, '0, '0);
        idle_o    = mk(1, 0, 0, 0, 0, '0, '0);
        fixed_exp = 64'hFFFF_FFFF_FFFF_FBFF;

        reset = 1'b1; req_valid = 1'b0; req_flush = 1'b0;
        req_addr = '0; req_mask = '0; dummy_data = '0;
        @(posedge clock);

        // Reset held: everything low.
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0, '0, '0, 1'b1, '0, zero_o);
        step("post_reset", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);

        // Plain flush.
        run_flush("flush", 1'b0);
        step("flush_ready", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);

        // Line invalidate with the documented constant result.
        step("line_acc", 1'b1, 1'b0, 6'h25, 2'b01, 1'b0, '1, idle_o);
        step("line_rd", 1'b0, 1'b0, '0, '0, 1'b0, '1, mk(0, 1, 0, 1, 0, 1'b1, '0));
        step("line_wr", 1'b0, 1'b0, '0, '0, 1'b0, '1, mk(0, 1, 0, 1, 1, 1'b1, fixed_exp));
        step("line_done", 1'b0, 1'b0, '0, '0, 1'b0, '1, mk(0, 1, 1, 0, 0, '0, '0));
        step("line_ready", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);

        // Request held through a flush; changed inputs while busy must be ignored.
        run_flush("hold", 1'b1);
        dd = {$urandom, $urandom};
        step("hold_acc2", 1'b1, 1'b0, 6'h03, 2'b10, 1'b0, dd, idle_o);
        step("hold_rd", 1'b1, 1'b0, 6'h3F, 2'b11, 1'b0, dd, mk(0, 1, 0, 1, 0, 1'b0, '0));
        step("hold_wr", 1'b1, 1'b0, 6'h3F, 2'b11, 1'b0, dd,
             mk(0, 1, 0, 1, 1, 1'b0, rmw(6'h03, 2'b10, dd)));
        step("hold_done", 1'b0, 1'b0, '0, '0, 1'b0, dd, mk(0, 1, 1, 0, 0, '0, '0));
        step("hold_ready", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);

        // Reset mid-flush with a simultaneous request: both dropped.
        step("rst_acc", 1'b1, 1'b1, '0, '0, 1'b0, '0, idle_o);
        step("rst_wr0", 1'b1, 1'b0, 6'h25, 2'b11, 1'b1, '0, mk(0, 1, 0, 1, 1, 1'b0, '0));
        step("rst_idle", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);
        step("rst_nodone", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);

        // Back-to-back: line accepted on the first ready cycle after a flush.
        run_flush("b2b_fl", 1'b0);
        run_line("b2b_line", 6'h1A, 2'b11, {$urandom, $urandom});

        // Zero mask: row rewritten unchanged.
        run_line("mask0", 6'h3F, 2'b00, {$urandom, $urandom});
        run_line("rand", 6'($urandom), 2'($urandom), {$urandom, $urandom});
        step("end_idle", 1'b0, 1'b0, '0, '0, 1'b0, '0, idle_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
